// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver with two-flop input synchronizer, mid-bit sampling and a
// one-entry valid/ready holding register; framing errors and overruns pulse.
module uart_rx_frame #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       rx,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             good_q, good_d;
    logic             ferr_pend_q, ferr_pend_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             busy_q, busy_d;
    logic             rx_s;

    assign rx_s = sync_q[1];

    always_comb begin
        sync_d      = {sync_q[0], rx};
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        good_d      = 1'b0;
        ferr_pend_d = 1'b0;
        if (!ena) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_d = S_START;
                        cnt_d   = HALF_M1;
                    end
                end
                S_START: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (!rx_s) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                        cnt_d   = BIT_M1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_DATA: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        shreg_d[idx_q] = rx_s;
                        cnt_d          = BIT_M1;
                        if (idx_q == 3'd7) begin
                            state_d = S_STOP;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (rx_s) begin
                        good_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_pend_d = 1'b1;
                        state_d     = S_WAIT_HIGH;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Stop-sample results are delayed one cycle so every output moves together.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = 1'b0;
        frame_err_d = ferr_pend_q;
        busy_d      = (state_q != S_IDLE);
        if (good_q) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = shreg_q;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= '1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            good_q      <= 1'b0;
            ferr_pend_q <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            good_q      <= good_d;
            ferr_pend_q <= ferr_pend_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at 16 clocks/bit; expected values are hand-derived
// from the frame timing (pin change just after edge E => out_valid rises after E+156).
module tb_uart_rx_frame;
    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       rx;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int ncmp  = 0;
    int nfail = 0;

    int busy_cnt = 0;
    int vrise_cnt = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    logic prev_valid = 1'b0;

    int b0, v0, f0, o0;

    uart_rx_frame #(.CLKS_PER_BIT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .rx        (rx),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if (frame_err === 1'b1) ferr_cnt++;
        if (overrun === 1'b1) ovr_cnt++;
        if (out_valid === 1'b1 && prev_valid !== 1'b1) vrise_cnt++;
        prev_valid = out_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start bit plus 8 data bits; leaves rx at the stop level, 1ns after edge E+144.
    task automatic send_bits(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        wait_cycles(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(16);
        end
        rx = stop;
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_bits(b, 1'b1);
        wait_cycles(16);
    endtask

    // Frame 0xF5 interrupted mid data bit 4 by ena low (mode 0) or rst (mode 1).
    task automatic send_aborted(input int mode);
        logic [7:0] b;
        b = 8'hF5;
        rx = 1'b0;
        wait_cycles(16);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            wait_cycles(16);
        end
        rx = b[4];
        wait_cycles(8);
        if (mode == 0) begin
            ena = 1'b0;
            wait_cycles(2);
            ena = 1'b1;
            wait_cycles(6);
        end else begin
            rst = 1'b1;
            wait_cycles(1);
            rst = 1'b0;
            wait_cycles(7);
        end
        for (int i = 5; i < 8; i++) begin
            rx = b[i];
            wait_cycles(16);
        end
        rx = 1'b1;
        wait_cycles(16);
    endtask

    initial begin
        rst = 1'b1;
        ena = 1'b1;
        rx = 1'b1;
        out_ready = 1'b0;

        // Reset and idle
        wait_cycles(3);
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 8'h00);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        b0 = busy_cnt; v0 = vrise_cnt;
        wait_cycles(200);
        check("idle_busy_cycles", busy_cnt - b0, 0);
        check("idle_valid_rises", vrise_cnt - v0, 0);
        check("idle_data", out_data, 8'h00);

        // Single byte: exact delivery edge
        send_bits(8'hA5, 1'b1);
        wait_cycles(11);
        check("a5_valid_early", out_valid, 1'b0);
        check("a5_busy_at_stop", busy, 1'b1);
        wait_cycles(1);
        check("a5_valid", out_valid, 1'b1);
        check("a5_data", out_data, 8'hA5);
        check("a5_busy_after", busy, 1'b0);
        check("a5_ferr", frame_err, 1'b0);
        wait_cycles(24);
        check("a5_valid_held", out_valid, 1'b1);
        out_ready = 1'b1;
        wait_cycles(1);
        out_ready = 1'b0;
        check("a5_consumed", out_valid, 1'b0);
        check("a5_data_kept", out_data, 8'hA5);

        // Overrun
        o0 = ovr_cnt;
        send_frame(8'h3C);
        check("3c_valid", out_valid, 1'b1);
        check("3c_data", out_data, 8'h3C);
        send_bits(8'hC3, 1'b1);
        wait_cycles(11);
        check("ovr_early", overrun, 1'b0);
        wait_cycles(1);
        check("ovr_pulse", overrun, 1'b1);
        check("ovr_data_kept", out_data, 8'h3C);
        check("ovr_valid", out_valid, 1'b1);
        wait_cycles(1);
        check("ovr_pulse_end", overrun, 1'b0);
        wait_cycles(3);
        check("ovr_count", ovr_cnt - o0, 1);

        // Simultaneous accept on the delivery edge
        send_bits(8'hC3, 1'b1);
        wait_cycles(11);
        out_ready = 1'b1;
        wait_cycles(1);
        out_ready = 1'b0;
        check("acc_valid", out_valid, 1'b1);
        check("acc_data", out_data, 8'hC3);
        check("acc_ovr", overrun, 1'b0);
        wait_cycles(4);
        check("acc_ovr_count", ovr_cnt - o0, 1);

        // Framing error followed by a long break
        f0 = ferr_cnt; v0 = vrise_cnt;
        send_bits(8'h55, 1'b0);
        wait_cycles(11);
        check("fe_early", frame_err, 1'b0);
        wait_cycles(1);
        check("fe_pulse", frame_err, 1'b1);
        check("fe_valid", out_valid, 1'b1);
        check("fe_data", out_data, 8'hC3);
        check("fe_busy_wait", busy, 1'b1);
        wait_cycles(1);
        check("fe_pulse_end", frame_err, 1'b0);
        wait_cycles(640);
        check("brk_busy", busy, 1'b1);
        check("brk_ferr_count", ferr_cnt - f0, 1);
        rx = 1'b1;
        wait_cycles(4);
        check("brk_release_busy", busy, 1'b0);
        b0 = busy_cnt;
        wait_cycles(40);
        check("brk_no_restart", busy_cnt - b0, 0);
        check("brk_ferr_final", ferr_cnt - f0, 1);
        check("brk_no_valid", vrise_cnt - v0, 0);
        check("brk_data", out_data, 8'hC3);
        out_ready = 1'b1;
        wait_cycles(1);
        out_ready = 1'b0;
        check("brk_consumed", out_valid, 1'b0);

        // False start
        b0 = busy_cnt; v0 = vrise_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        rx = 1'b0;
        wait_cycles(4);
        rx = 1'b1;
        wait_cycles(30);
        check("fs_busy_bounded", ((busy_cnt - b0) >= 1 && (busy_cnt - b0) <= 9), 1'b1);
        check("fs_busy_low", busy, 1'b0);
        check("fs_no_valid", vrise_cnt - v0, 0);
        check("fs_no_ferr", ferr_cnt - f0, 0);
        check("fs_no_ovr", ovr_cnt - o0, 0);

        // Abort by ena, then by rst
        send_aborted(0);
        check("ena_abort_no_valid", vrise_cnt - v0, 0);
        check("ena_abort_busy", busy, 1'b0);
        check("ena_abort_ferr", ferr_cnt - f0, 0);
        check("ena_abort_data", out_data, 8'hC3);
        send_aborted(1);
        check("rst_abort_no_valid", vrise_cnt - v0, 0);
        check("rst_abort_busy", busy, 1'b0);
        check("rst_abort_data", out_data, 8'h00);
        check("rst_abort_ferr", ferr_cnt - f0, 0);
        send_frame(8'h0F);
        check("0f_valid", out_valid, 1'b1);
        check("0f_data", out_data, 8'h0F);
        check("0f_one_rise", vrise_cnt - v0, 1);
        check("0f_no_ovr", ovr_cnt - o0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Serial byte receiver that sits directly upstream of the `tt_um_mmorri22_cse_30342` user logic. It recovers 8N1 UART frames from one dedicated input pin, oversampling at a fixed number of clocks per bit. Received bytes are presented on a one-entry valid/ready holding register, and the user logic consumes them from there. Framing errors and overruns are reported as single-cycle pulses.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range 4..65535. Counter width is `$clog2(CLKS_PER_BIT)`.

Ports:
- `clk`  input  1  the single design clock.
- `rst`  input  1  synchronous, active-high reset. The top level drives it as `~rst_n`.
- `ena`  input  1  design-selected. While low, the receiver is forced to IDLE at each clock edge. The holding register is left untouched.
- `rx`  input  1  asynchronous serial line (`ui_in[0]`). Idles high.
- `out_data`  output  8  received byte, LSB = first data bit on the wire.
- `out_valid`  output  1  `out_data` holds an unconsumed byte.
- `out_ready`  input  1  consumer accepts the byte on a clock edge where `out_valid && out_ready`.
- `frame_err`  output  1  one-cycle pulse: the stop bit was sampled low.
- `overrun`  output  1  one-cycle pulse: a good byte was dropped because the holding register was full.
- `busy`  output  1  high in every state except IDLE.

## Operation
- Input synchronizer: `rx` passes through 2 flops to produce `rx_s`. The synchronizer resets to 1.
- States are IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - If `ena` is high and `rx_s` is 0, go to START and load the counter with H-1, where H = `CLKS_PER_BIT/2` (floor).
- START:
  - Count down to 0, then sample `rx_s`.
  - If the sample is 0: go to DATA, bit index = 0, counter = `CLKS_PER_BIT-1`.
  - If the sample is 1 (glitch / false start): go to IDLE with no output.
- DATA:
  - At each counter expiry, shift `rx_s` into bit[index] (LSB first) and reload the counter.
  - After the sample with index 7, go to STOP.
- STOP:
  - At counter expiry, sample `rx_s`.
  - If the sample is 1: the byte is good and the state goes to IDLE.
  - If the sample is 0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until `rx_s` is 1, then go to IDLE. This prevents a break condition from re-triggering.
- Good-byte delivery (on the edge after the stop sample):
  - If `out_valid` is 0, or `out_valid && out_ready` on that same edge: load `out_data` and set `out_valid`. No overrun.
  - Otherwise: keep the old `out_data`/`out_valid` and pulse `overrun`.
- Consumption: `out_valid && out_ready` with no simultaneous good byte clears `out_valid`. `out_data` keeps its last value.
- `ena` low mid-frame: abort to IDLE, no pulses. The partial byte is discarded.
- `rst` mid-frame: every register returns to its reset value on that edge. Any partial byte is lost.

## Timing
- Reset values: `out_data`=0x00, `out_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0, state=IDLE, both synchronizer flops=1.
- Let t0 be the edge where IDLE sees `rx_s`=0. The pin edge precedes t0 by 2–3 cycles (synchronizer).
- Sample points, all relative to t0:
  - Start check at t0+H.
  - Data bit i at t0+H+(i+1)·`CLKS_PER_BIT`.
  - Stop bit at t0+H+9·`CLKS_PER_BIT`.
- Outputs update at stop sample +1 cycle:
  - `out_valid` rises, or `overrun` / `frame_err` pulses, one cycle wide.
- `busy` is high from t0+1 through the stop-sample edge. It returns low at stop sample +1.
- Back-to-back frames: a new start bit can be detected on the first IDLE cycle after the stop sample. No gap beyond the stop bit is required.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
(CLKS_PER_BIT=16, H=8, `ena`=1 unless stated.)
- Reset/idle:
  - Stimulus: hold `rst`=1 for 3 cycles with `rx`=1, release, then wait 200 cycles.
  - Required: all outputs 0, `busy`=0 throughout.
- Single byte:
  - Stimulus: drive 0xA5 as 8N1 at 16 clk/bit, `out_ready`=0.
  - Required: `out_valid` rises exactly t0+153; `out_data`=0xA5; `out_valid` stays high until `out_ready` is pulsed, then falls the next edge.
- Overrun and simultaneous accept:
  - Stimulus: send 0x3C then 0xC3 with `out_ready`=0.
  - Required: `overrun` pulses once and `out_data` stays 0x3C.
  - Stimulus: repeat, asserting `out_ready` exactly on the 0xC3 delivery edge.
  - Required: `out_data`=0xC3, `out_valid`=1, no `overrun`.
- Framing error / break:
  - Stimulus: send 0x55 with stop bit forced low, then hold `rx`=0 for 40 bit times, then release high.
  - Required: one `frame_err` pulse, `out_valid` unchanged, no new start until after `rx` returns high.
- False start:
  - Stimulus: pull `rx` low for 4 cycles, then high.
  - Required: `busy` high for ≤H+1 cycles, then low; no `out_valid`, no error pulses.
- Abort:
  - Stimulus: deassert `ena` (and separately assert `rst`) during data bit 4 of a frame, then send 0x0F cleanly.
  - Required: no output from the aborted frame; 0x0F is received correctly.
